// File: rtl/mult_pkg.sv
// Shared types for the multiplier sequencer: FSM states, operating mode
// and the per-cycle datapath operation, plus the Q0/Qm1 decode helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    BOOTH    = 1'b1
  } mult_mode_t;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'd0,
    OP_ADD   = 2'd1,
    OP_SUB   = 2'd2
  } run_op_t;

  // Unsigned add-shift looks only at Q0; Booth radix-2 looks at the pair
  // {Q0,Qm1}: 10 starts a run of ones (subtract), 01 ends one (add).
  function automatic run_op_t decode_op(input mult_mode_t m, input logic q0, input logic qm1);
    run_op_t op;
    if (m == UNSIGNED) begin
      op = q0 ? OP_ADD : OP_SHIFT;
    end else begin
      case ({q0, qm1})
        2'b10:   op = OP_SUB;
        2'b01:   op = OP_ADD;
        default: op = OP_SHIFT;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mult_down_counter.sv
// Loadable down-counter holding the remaining RUN iterations.
module mult_down_counter
  import mult_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value
);

  // Load has priority over decrement; reset clears to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - CW'(1);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-add / Booth radix-2 multiplier datapath.
// Optional feature: define MULT_SEQ_EARLY_EXIT_EN to let RUN finish early
// with a single align step once the remaining multiplier bits are zero.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode,
  input  logic                       Q0,
  input  logic                       Qm1,
  input  logic                       q_zero,
  output logic                       load,
  output logic                       add_shift,
  output logic                       sub_shift,
  output logic                       shift,
  output logic                       align,
  output logic                       ready,
  output logic                       done,
  output logic [$clog2(N+1)-1:0]     count
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  seq_state_t       state_r;
  seq_state_t       state_s;
  mult_mode_t       mode_r;
  logic             cnt_dec_s;
  logic             early_exit_s;
  logic [CW-1:0]    cnt_value_s;
  run_op_t          op_s;

  // Iteration counter: loaded with N while in LOAD, counts down in RUN.
  mult_down_counter #(.CW(CW)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (state_r == LOAD),
    .dec        (cnt_dec_s),
    .load_value (N_CNT),
    .value      (cnt_value_s)
  );

  assign count = cnt_value_s;
  assign op_s  = decode_op(mode_r, Q0, Qm1);

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Booth with Qm1=1 still owes a final add, so it cannot skip ahead.
  assign early_exit_s = q_zero && (cnt_value_s > CW'(1)) &&
                        !((mode_r == BOOTH) && Qm1);
`else
  assign early_exit_s = q_zero & 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Mode is captured only when a start is accepted in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_r <= UNSIGNED;
    end else if ((state_r == IDLE) && start) begin
      mode_r <= mult_mode_t'(mode);
    end else begin
      mode_r <= mode_r;
    end
  end

  // Next-state and output decode; abort wins over any RUN operation.
  always_comb begin
    state_s   = state_r;
    load      = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    add_shift = 1'b0;
    sub_shift = 1'b0;
    shift     = 1'b0;
    align     = 1'b0;
    cnt_dec_s = 1'b0;
    case (state_r)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (abort) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          cnt_dec_s = 1'b1;
          if (early_exit_s) begin
            align   = 1'b1;
            state_s = DONE;
          end else begin
            case (op_s)
              OP_ADD:  add_shift = 1'b1;
              OP_SUB:  sub_shift = 1'b1;
              default: shift     = 1'b1;
            endcase
            if (cnt_value_s == CW'(1)) begin
              state_s = DONE;
            end else begin
              state_s = RUN;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer (N=4). Expected operations come
// from an arithmetic model of the multiplication recoding rules.
module tb_mult_sequencer;

  localparam int N  = 4;
  localparam int CW = $clog2(N+1);

  localparam logic [3:0] E_NONE  = 4'b0000;
  localparam logic [3:0] E_SHIFT = 4'b0001;
  localparam logic [3:0] E_ADD   = 4'b0010;
  localparam logic [3:0] E_SUB   = 4'b0100;
  localparam logic [3:0] E_ALIGN = 4'b1000;

  logic clock = 1'b0;
  logic reset, start, abort, mode, Q0, Qm1, q_zero;
  logic load, add_shift, sub_shift, shift, align, ready, done;
  logic [CW-1:0] count;
  logic [3:0] ops_s;

  int tests = 0;
  int fails = 0;

  mult_sequencer #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .Q0(Q0), .Qm1(Qm1), .q_zero(q_zero), .load(load), .add_shift(add_shift),
    .sub_shift(sub_shift), .shift(shift), .align(align), .ready(ready),
    .done(done), .count(count)
  );

  assign ops_s = {align, sub_shift, add_shift, shift};

  always #5 clock = ~clock;

  // Reference: unsigned adds the multiplicand when the bit is 1; Booth
  // weight is (Qm1 - Q0): +1 add, -1 subtract, 0 shift only.
  function automatic logic [3:0] ref_op(input logic m, input logic q0, input logic qm1);
    int d;
    if (!m) return q0 ? E_ADD : E_SHIFT;
    d = int'(qm1) - int'(q0);
    if (d == 1) return E_ADD;
    else if (d == -1) return E_SUB;
    else return E_SHIFT;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    Q0 = 1'b0; Qm1 = 1'b0; q_zero = 1'b0;
    #1;
    tests++;
    if ({ready, load, done, ops_s} !== {1'b1, 1'b0, 1'b0, E_NONE}) begin
      fails++; $display("FAIL reset_outputs: got %b expected %b", {ready, load, done, ops_s}, 7'b1000000);
    end
    tests++;
    if (count !== CW'(0)) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  // One full multiplication; qb[2i+1:2i] = {Q0,Qm1} for RUN cycle i.
  task automatic do_mult(input logic m, input logic [2*N-1:0] qb, input string name);
    logic [3:0] exp_op;
    @(negedge clock); start = 1'b1; mode = m; abort = 1'b0; q_zero = 1'b0;
    tests++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL %s_ready: got %b expected 1", name, ready);
    end
    @(negedge clock); start = 1'b0; mode = ~m; #1;
    tests++;
    if ({load, ready, done, ops_s} !== {1'b1, 1'b0, 1'b0, E_NONE}) begin
      fails++; $display("FAIL %s_load: got %b expected %b", name, {load, ready, done, ops_s}, 7'b1000000);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clock); {Q0, Qm1} = qb[2*i +: 2]; #1;
      exp_op = ref_op(m, Q0, Qm1);
      tests++;
      if ({ops_s, load, done} !== {exp_op, 1'b0, 1'b0}) begin
        fails++; $display("FAIL %s_op%0d: got %b expected %b", name, i, {ops_s, load, done}, {exp_op, 2'b00});
      end
      tests++;
      if (count !== CW'(N - i)) begin
        fails++; $display("FAIL %s_count%0d: got %0d expected %0d", name, i, count, N - i);
      end
    end
    @(negedge clock); #1;
    tests++;
    if ({done, ready, ops_s} !== {1'b1, 1'b0, E_NONE}) begin
      fails++; $display("FAIL %s_done: got %b expected %b", name, {done, ready, ops_s}, 6'b100000);
    end
    @(negedge clock); #1;
    tests++;
    if ({ready, done, load} !== 3'b100) begin
      fails++; $display("FAIL %s_idle: got %b expected 100", name, {ready, done, load});
    end
  endtask

  task automatic test_unsigned();
    do_mult(1'b0, {2'b10, 2'b10, 2'b00, 2'b10}, "unsigned_1011");
  endtask

  task automatic test_booth();
    do_mult(1'b1, {2'b00, 2'b01, 2'b11, 2'b10}, "booth_10_11_01_00");
  endtask

  task automatic test_random();
    logic m;
    logic [2*N-1:0] qb;
    for (int r = 0; r < 16; r++) begin
      m  = 1'($urandom_range(0, 1));
      qb = (2*N)'($urandom);
      do_mult(m, qb, "random");
    end
  endtask

  task automatic test_start_held();
    int loads = 0, opsn = 0, dones = 0;
    @(negedge clock); start = 1'b1; mode = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock); Q0 = 1'($urandom); Qm1 = 1'($urandom); #1;
      if (k <= 7) begin
        loads += int'(load); dones += int'(done); opsn += int'(|ops_s);
      end
      if (k == 8) begin
        tests++;
        if (load !== 1'b1) begin
          fails++; $display("FAIL held_second_load: got %b expected 1", load);
        end
      end
    end
    tests++;
    if ({loads, opsn, dones} !== {32'd1, 32'd4, 32'd1}) begin
      fails++; $display("FAIL held_counts: got loads=%0d ops=%0d dones=%0d expected 1 4 1", loads, opsn, dones);
    end
    start = 1'b0;
    for (int j = 0; j < 20 && ready !== 1'b1; j++) begin
      @(negedge clock); #1;
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL held_return_idle: got %b expected 1", ready);
    end
  endtask

  task automatic test_abort();
    @(negedge clock); start = 1'b1; mode = 1'b0;
    @(negedge clock); start = 1'b0;
    @(negedge clock); Q0 = 1'b1;
    @(negedge clock); abort = 1'b1; #1;
    tests++;
    if (ops_s !== E_NONE) begin
      fails++; $display("FAIL abort_ops: got %b expected 0000", ops_s);
    end
    @(negedge clock); abort = 1'b0; #1;
    tests++;
    if ({ready, done, load} !== 3'b100) begin
      fails++; $display("FAIL abort_idle: got %b expected 100", {ready, done, load});
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); #1;
      tests++;
      if (done !== 1'b0) begin
        fails++; $display("FAIL abort_no_done: got %b expected 0", done);
      end
    end
  endtask

  task automatic test_idle_abort();
    @(negedge clock); start = 1'b1; abort = 1'b1; mode = 1'b0;
    @(negedge clock); start = 1'b0; abort = 1'b0; #1;
    tests++;
    if (load !== 1'b1) begin
      fails++; $display("FAIL idle_abort_load: got %b expected 1", load);
    end
    for (int j = 0; j < 20 && ready !== 1'b1; j++) begin
      @(negedge clock); #1;
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL idle_abort_return: got %b expected 1", ready);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clock); start = 1'b1; mode = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); {Q0, Qm1} = 2'b10;
    @(negedge clock); {Q0, Qm1} = 2'b01;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({ready, load, done, ops_s} !== {1'b1, 1'b0, 1'b0, E_NONE}) begin
      fails++; $display("FAIL midrun_reset_outputs: got %b expected 1000000", {ready, load, done, ops_s});
    end
    tests++;
    if (count !== CW'(0)) begin
      fails++; $display("FAIL midrun_reset_count: got %0d expected 0", count);
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #1;
    tests++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL midrun_reset_idle: got %b expected 1", ready);
    end
  endtask

  task automatic test_early_exit();
    @(negedge clock); start = 1'b1; mode = 1'b0; q_zero = 1'b0;
    @(negedge clock); start = 1'b0;
    @(negedge clock); Q0 = 1'b1; #1;
    tests++;
    if (ops_s !== E_ADD) begin
      fails++; $display("FAIL early_first_op: got %b expected %b", ops_s, E_ADD);
    end
    @(negedge clock); Q0 = 1'b0; q_zero = 1'b1; #1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    tests++;
    if ({ops_s, count} !== {E_ALIGN, CW'(3)}) begin
      fails++; $display("FAIL early_align: got ops=%b count=%0d expected %b count=3", ops_s, count, E_ALIGN);
    end
`else
    tests++;
    if ({ops_s, count} !== {E_SHIFT, CW'(3)}) begin
      fails++; $display("FAIL early_disabled_op2: got ops=%b count=%0d expected %b count=3", ops_s, count, E_SHIFT);
    end
    for (int i = 2; i < N; i++) begin
      @(negedge clock); Q0 = 1'b1; #1;
      tests++;
      if (ops_s !== E_ADD) begin
        fails++; $display("FAIL early_disabled_op%0d: got %b expected %b", i, ops_s, E_ADD);
      end
    end
`endif
    @(negedge clock); q_zero = 1'b0; #1;
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL early_done: got %b expected 1", done);
    end
    @(negedge clock); #1;
    tests++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL early_idle: got %b expected 1", ready);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_booth();
    test_random();
    test_start_held();
    test_abort();
    test_idle_abort();
    test_reset_mid_run();
    test_early_exit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
